// File: rtl/mem_stage_ctrl.sv
// MEM-stage load/store sequencer: one req/ack bus transaction per memory op, with pipeline stall,
// byte-lane steering, load formatting and fault reporting. Optional MEM_TIMEOUT_EN adds a BUSY watchdog.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        me_valid,
  input  logic        me_flush,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic [2:0]  me_func3_code,
  input  logic [31:0] me_alu_o,
  input  logic [31:0] me_regs_data2,
  output logic        stall_o,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic        dbus_err,
  input  logic [31:0] dbus_rdata,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic        dbus_req_q;
  logic        dbus_we_q;
  logic [31:0] dbus_addr_q;
  logic [3:0]  dbus_be_q;
  logic [31:0] dbus_wdata_q;
  logic [2:0]  func3_q;
  logic [1:0]  k_q;
  logic        load_valid_q;
  logic [31:0] load_data_q;
  logic        fault_valid_q;
  logic [1:0]  fault_cause_q;
  logic [31:0] fault_addr_q;

  logic        access;
  logic        legal;
  logic        aligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_shifted;
  logic [31:0] load_fmt_d;
  logic        timeout_hit;

  assign access = me_valid && !me_flush && (me_mem_read || me_mem_write);

  always_comb begin
    legal = 1'b0;
    if (me_mem_read && !me_mem_write) begin
      case (me_func3_code)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                 legal = 1'b0;
      endcase
    end else if (me_mem_write && !me_mem_read) begin
      case (me_func3_code)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (me_func3_code[1:0])
      2'b01:   aligned = !me_alu_o[0];
      2'b10:   aligned = (me_alu_o[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Store lanes are steered by the byte offset; loads always fetch the whole word.
  always_comb begin
    be_d    = 4'hF;
    wdata_d = me_regs_data2;
    if (me_mem_write) begin
      case (me_func3_code[1:0])
        2'b00: begin
          be_d    = 4'b0001 << me_alu_o[1:0];
          wdata_d = {4{me_regs_data2[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << me_alu_o[1:0];
          wdata_d = {2{me_regs_data2[15:0]}};
        end
        default: begin
          be_d    = 4'hF;
          wdata_d = me_regs_data2;
        end
      endcase
    end
  end

  assign rdata_shifted = dbus_rdata >> {k_q, 3'b000};

  always_comb begin
    case (func3_q)
      3'b000:  load_fmt_d = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_fmt_d = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_fmt_d = {24'h000000, rdata_shifted[7:0]};
      3'b101:  load_fmt_d = {16'h0000, rdata_shifted[15:0]};
      default: load_fmt_d = rdata_shifted;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  logic [CNT_W-1:0] cnt_q;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      dbus_req_q    <= 1'b0;
      dbus_we_q     <= 1'b0;
      dbus_addr_q   <= '0;
      dbus_be_q     <= '0;
      dbus_wdata_q  <= '0;
      func3_q       <= '0;
      k_q           <= '0;
      load_valid_q  <= 1'b0;
      load_data_q   <= '0;
      fault_valid_q <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      load_valid_q  <= 1'b0;
      fault_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            if (legal && aligned) begin
              state_q      <= BUSY;
              dbus_req_q   <= 1'b1;
              dbus_we_q    <= me_mem_write;
              dbus_addr_q  <= {me_alu_o[31:2], 2'b00};
              dbus_be_q    <= be_d;
              dbus_wdata_q <= wdata_d;
              func3_q      <= me_func3_code;
              k_q          <= me_alu_o[1:0];
`ifdef MEM_TIMEOUT_EN
              cnt_q        <= '0;
`endif
            end else begin
              state_q       <= DONE;
              fault_valid_q <= 1'b1;
              fault_cause_q <= 2'b01;
              fault_addr_q  <= me_alu_o;
            end
          end
        end
        BUSY: begin
          if (dbus_err) begin
            state_q       <= DONE;
            dbus_req_q    <= 1'b0;
            fault_valid_q <= 1'b1;
            fault_cause_q <= 2'b10;
            fault_addr_q  <= {dbus_addr_q[31:2], k_q};
          end else if (dbus_ack) begin
            state_q    <= DONE;
            dbus_req_q <= 1'b0;
            if (!dbus_we_q) begin
              load_valid_q <= 1'b1;
              load_data_q  <= load_fmt_d;
            end
          end else if (timeout_hit) begin
            // Request is abandoned; the slave tolerates a dropped req.
            state_q       <= DONE;
            dbus_req_q    <= 1'b0;
            fault_valid_q <= 1'b1;
            fault_cause_q <= 2'b11;
            fault_addr_q  <= {dbus_addr_q[31:2], k_q};
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o     = ((state_q == IDLE) && access) || (state_q == BUSY);
  assign dbus_req    = dbus_req_q;
  assign dbus_we     = dbus_we_q;
  assign dbus_addr   = dbus_addr_q;
  assign dbus_be     = dbus_be_q;
  assign dbus_wdata  = dbus_wdata_q;
  assign load_valid  = load_valid_q;
  assign load_data   = load_data_q;
  assign fault_valid = fault_valid_q;
  assign fault_cause = fault_cause_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: table of single transactions plus multi-cycle corner sequences.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        me_valid, me_flush, me_mem_read, me_mem_write;
  logic [2:0]  me_func3_code;
  logic [31:0] me_alu_o, me_regs_data2;
  logic        stall_o, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack, dbus_err;
  logic [31:0] dbus_rdata;
  logic        load_valid, fault_valid;
  logic [31:0] load_data, fault_addr;
  logic [1:0]  fault_cause;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_ld    = 32'h0;
  logic [31:0] last_faddr = 32'h0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .me_valid(me_valid), .me_flush(me_flush),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
    .me_func3_code(me_func3_code), .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2),
    .stall_o(stall_o),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_err(dbus_err), .dbus_rdata(dbus_rdata),
    .load_valid(load_valid), .load_data(load_data),
    .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] d;
    logic [31:0] rdata;
    logic        bus;
    logic [31:0] eaddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        lv;
    logic [31:0] ldata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    me_valid = 0; me_flush = 0; me_mem_read = 0; me_mem_write = 0;
    dbus_ack = 0; dbus_err = 0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] d);
    me_valid = 1; me_flush = 0; me_mem_read = rd; me_mem_write = wr;
    me_func3_code = f3; me_alu_o = addr; me_regs_data2 = d;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive(v.rd, v.wr, v.f3, v.addr, v.d);
    dbus_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d stall_idle", i), {31'b0, stall_o}, 32'd1);
    step();
    if (v.bus) begin
      chk($sformatf("v%0d req", i), {31'b0, dbus_req}, 32'd1);
      chk($sformatf("v%0d we", i), {31'b0, dbus_we}, {31'b0, v.wr});
      chk($sformatf("v%0d addr", i), dbus_addr, v.eaddr);
      chk($sformatf("v%0d be", i), {28'b0, dbus_be}, {28'b0, v.be});
      if (v.wr) chk($sformatf("v%0d wdata", i), dbus_wdata, v.wdata);
      chk($sformatf("v%0d stall_busy", i), {31'b0, stall_o}, 32'd1);
      dbus_ack = 1;
      step();
      dbus_ack = 0;
      chk($sformatf("v%0d req_done", i), {31'b0, dbus_req}, 32'd0);
      chk($sformatf("v%0d stall_done", i), {31'b0, stall_o}, 32'd0);
      chk($sformatf("v%0d load_valid", i), {31'b0, load_valid}, {31'b0, v.lv});
      chk($sformatf("v%0d fault_valid", i), {31'b0, fault_valid}, 32'd0);
      if (v.lv) begin
        chk($sformatf("v%0d load_data", i), load_data, v.ldata);
        last_ld = v.ldata;
      end
    end else begin
      chk($sformatf("v%0d req_none", i), {31'b0, dbus_req}, 32'd0);
      chk($sformatf("v%0d stall_done", i), {31'b0, stall_o}, 32'd0);
      chk($sformatf("v%0d fault_valid", i), {31'b0, fault_valid}, 32'd1);
      chk($sformatf("v%0d fault_cause", i), {30'b0, fault_cause}, 32'd1);
      chk($sformatf("v%0d fault_addr", i), fault_addr, v.addr);
      chk($sformatf("v%0d load_valid", i), {31'b0, load_valid}, 32'd0);
      last_faddr = v.addr;
    end
    idle_inputs();
    step();
    chk($sformatf("v%0d lv_pulse", i), {31'b0, load_valid}, 32'd0);
    chk($sformatf("v%0d fv_pulse", i), {31'b0, fault_valid}, 32'd0);
    chk($sformatf("v%0d load_hold", i), load_data, last_ld);
    chk($sformatf("v%0d faddr_hold", i), fault_addr, last_faddr);
    $display("vec %0d rd=%0d wr=%0d f3=%b addr=%h done", i, v.rd, v.wr, v.f3, v.addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h1000, 32'h0,        32'hDEADBEEF, 1'b1, 32'h1000, 4'hF, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h2003, 32'h000000A5, 32'h0,        1'b1, 32'h2000, 4'h8, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h3001, 32'h0,        32'h00008000, 1'b1, 32'h3000, 4'hF, 32'h0,        1'b1, 32'hFFFFFF80};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h3001, 32'h0,        32'h00008000, 1'b1, 32'h3000, 4'hF, 32'h0,        1'b1, 32'h00000080};
    vecs[4]  = '{1'b1, 1'b0, 3'b000, 32'h3001, 32'h0,        32'h0000F000, 1'b1, 32'h3000, 4'hF, 32'h0,        1'b1, 32'hFFFFFFF0};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h3002, 32'h0,        32'h80010000, 1'b1, 32'h3000, 4'hF, 32'h0,        1'b1, 32'hFFFF8001};
    vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h3002, 32'h0,        32'h80010000, 1'b1, 32'h3000, 4'hF, 32'h0,        1'b1, 32'h00008001};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h5002, 32'h1234ABCD, 32'h0,        1'b1, 32'h5000, 4'hC, 32'hABCDABCD, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h6004, 32'hCAFEF00D, 32'h0,        1'b1, 32'h6004, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h4001, 32'h0,        32'h0,        1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h4002, 32'h0,        32'h0,        1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h0100, 32'h0,        32'h0,        1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0200, 32'h0,        32'h0,        1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h0300, 32'h0,        32'h0,        1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 3'b100, 32'h7003, 32'h0,        32'hAB000000, 1'b1, 32'h7000, 4'hF, 32'h0,        1'b1, 32'h000000AB};
    vecs[15] = '{1'b1, 1'b0, 3'b001, 32'h7000, 32'h0,        32'h12347FFF, 1'b1, 32'h7000, 4'hF, 32'h0,        1'b1, 32'h00007FFF};
    vecs[16] = '{1'b0, 1'b1, 3'b000, 32'h7001, 32'h0000005A, 32'h0,        1'b1, 32'h7000, 4'h2, 32'h5A5A5A5A, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h7FFC, 32'h0,        32'h01020304, 1'b1, 32'h7FFC, 4'hF, 32'h0,        1'b1, 32'h01020304};

    // Reset state
    rstn = 0;
    idle_inputs();
    me_func3_code = 0; me_alu_o = 0; me_regs_data2 = 0; dbus_rdata = 0;
    #3;
    chk("rst_outputs",
        {24'b0, stall_o, dbus_req, dbus_we, load_valid, fault_valid, fault_cause, 1'b0},
        32'h0);
    chk("rst_addr_be", dbus_addr | {28'b0, dbus_be}, 32'h0);
    chk("rst_data", dbus_wdata | load_data | fault_addr, 32'h0);
    step();
    step();
    rstn = 1;
    step();

    for (int i = 0; i < NV; i++) run_vec(i);

    // Flush in IDLE: no access, no stall
    drive(1, 0, 3'b010, 32'h1000, 32'h0);
    me_flush = 1;
    #1;
    chk("flush_stall", {31'b0, stall_o}, 32'd0);
    step();
    chk("flush_req", {31'b0, dbus_req}, 32'd0);
    step();
    chk("flush_pulses", {30'b0, load_valid, fault_valid}, 32'd0);
    idle_inputs();
    step();
    $display("seq flush_idle done");

    // Ack/err outside BUSY are ignored
    dbus_ack = 1; dbus_err = 1;
    step();
    step();
    chk("stray_ack", {29'b0, dbus_req, load_valid, fault_valid}, 32'd0);
    idle_inputs();
    step();
    $display("seq stray_ack done");

    // SW with wait states, err+ack together in 3rd BUSY cycle
    drive(0, 1, 3'b010, 32'h8008, 32'h11223344);
    step();
    chk("werr_busy1_req", {31'b0, dbus_req}, 32'd1);
    step();
    chk("werr_busy2_stall", {30'b0, stall_o, dbus_req}, 32'd3);
    step();
    chk("werr_busy3_addr", dbus_addr, 32'h8008);
    chk("werr_busy3_wdata", dbus_wdata, 32'h11223344);
    dbus_err = 1; dbus_ack = 1;
    step();
    dbus_err = 0; dbus_ack = 0;
    chk("werr_req_drop", {31'b0, dbus_req}, 32'd0);
    chk("werr_fault_valid", {31'b0, fault_valid}, 32'd1);
    chk("werr_cause", {30'b0, fault_cause}, 32'd2);
    chk("werr_faddr", fault_addr, 32'h8008);
    chk("werr_no_load", {31'b0, load_valid}, 32'd0);
    last_faddr = 32'h8008;
    idle_inputs();
    step();
    $display("seq store_err done");

    // Flush during BUSY is ignored; result still pulses
    drive(1, 0, 3'b101, 32'h9002, 32'h0);
    dbus_rdata = 32'hBEEF0000;
    step();
    me_flush = 1;
    step();
    chk("bflush_req", {31'b0, dbus_req}, 32'd1);
    dbus_ack = 1;
    step();
    dbus_ack = 0;
    chk("bflush_lv", {31'b0, load_valid}, 32'd1);
    chk("bflush_ld", load_data, 32'h0000BEEF);
    last_ld = 32'h0000BEEF;
    idle_inputs();
    step();
    $display("seq flush_busy done");

    // No ack: timeout, or indefinite wait
    drive(1, 0, 3'b010, 32'hA000, 32'h0);
`ifdef MEM_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("to_busy%0d", c), {30'b0, stall_o, dbus_req}, 32'd3);
    end
    step();
    chk("to_fault_valid", {31'b0, fault_valid}, 32'd1);
    chk("to_cause", {30'b0, fault_cause}, 32'd3);
    chk("to_faddr", fault_addr, 32'hA000);
    chk("to_req_drop", {31'b0, dbus_req}, 32'd0);
    idle_inputs();
    step();
    drive(1, 0, 3'b010, 32'hB000, 32'h0);
    step();
`else
    for (int c = 0; c < 100; c++) begin
      step();
      chk($sformatf("stuck%0d", c), {30'b0, stall_o, dbus_req}, 32'd3);
    end
`endif
    $display("seq no_ack done");

    // Asynchronous reset mid-BUSY
    chk("rbusy_req", {31'b0, dbus_req}, 32'd1);
    #2;
    rstn = 0;
    idle_inputs();
    #1;
    chk("rbusy_req_drop", {31'b0, dbus_req}, 32'd0);
    chk("rbusy_stall", {31'b0, stall_o}, 32'd0);
    step();
    rstn = 1;
    step();
    $display("seq reset_busy done");

    // Recovery after reset
    last_ld = 32'h0;
    last_faddr = 32'h0;
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
